fetch_lsu_wb: RTL and testbench
===============================

Name: fetch_lsu_wb

Overview:
Unified instruction-fetch and load/store write-back unit with a byte-enabled, dual-port, single-clock RAM.
- Port A fetches instructions from a PC counter that supports stall and redirect, and tags each fetched instruction with valid.
- Port B executes RV32 byte, halfword and word loads and stores, with lane alignment, sign/zero extension and error detection.
- Produces a register write-back op.
- Sits between decode/execute (which supply fetch control and memory ops) and the register file.

Parameters:
cXLEN, 32, data and instruction width; fixed at 32 for RV32; byte lanes = cXLEN/8.
cRamDepth, 1024, RAM depth in words; power of two, at least 16.
cResetPc, 0, PC value after reset; low 2 bits must be 0.
cRdW, 5, register destination address width.

Ports:
iClk  in  1  clock, rising edge
iRst  in  1  reset, synchronous, active-low
iStall  in  1  hold fetch PC and fetch outputs
iRedirect  in  1  load new PC
iNewPc  in  cXLEN  redirect target
iMemRead  in  1  load request
iMemWrite  in  1  store request
iMemOpType  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
iMemAddr  in  cXLEN  byte address
iMemData  in  cXLEN  store data, LSB-justified
iRdAddr  in  cRdW  load destination register
oInstr  out  cXLEN  fetched instruction
oCurPc  out  cXLEN  PC of oInstr
oInstrValid  out  1  oInstr is architecturally valid
oRegDv  out  1  write-back valid, one-cycle pulse
oRegAddr  out  cRdW  write-back register
oRegData  out  cXLEN  extended load data
oMemErr  out  1  one-cycle pulse: misaligned, illegal opType, or read and write together

Behaviour:
- Reset (iRst=0, sampled on the clock edge) drives the following values:
  - pc = cResetPc, FSM = FLUSH;
  - oInstrValid, oRegDv and oMemErr are 0;
  - oCurPc, oInstr, oRegAddr and oRegData are 0;
  - no RAM write during reset.
- Word index is addr[log2(cRamDepth)+1:2]. Upper address bits are ignored, so accesses wrap.

Fetch FSM (states RUN, FLUSH):
- Each cycle that is not stalled issues a read at pc. The result appears on oInstr one cycle later, with oCurPc equal to the issued pc; this is a registered copy, not pc-4.
- oInstrValid=1 in RUN and 0 in FLUSH.
- Priority for the next pc: reset > iRedirect > iStall > pc+4.
- iRedirect:
  - pc <= {iNewPc[cXLEN-1:2],2'b00};
  - the read issued that cycle is squashed (FSM -> FLUSH), so the next cycle has oInstrValid=0;
  - the following cycle returns to RUN and presents iNewPc.
- iStall (no redirect): pc, oInstr, oCurPc, oInstrValid and FSM all hold; the port A enable is deasserted.
- First fetch after reset release: cycle 0 has valid=0; cycle 1 shows cResetPc with valid=1.

Load/store pipeline (independent of iStall and iRedirect):
- Cycle t: request accepted if exactly one of iMemRead or iMemWrite is set.
- Error conditions, which pulse oMemErr at t+1 and drop the op (no write, no oRegDv):
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - opType not in the legal set;
  - read and write asserted together.
- Store at t+1 edge:
  - sb: byte replicated to all lanes, byte-enable = 1<<addr[1:0];
  - sh: halfword replicated, byte-enable = 4'b0011<<(2*addr[1]);
  - sw: byte-enable = 4'b1111.
- Load:
  - RAM read at t+1, data at t+2;
  - lane select and extension registered, so oRegDv=1 at t+3 with oRegAddr = iRdAddr captured at t;
  - b and h sign-extend, bu and hu zero-extend;
  - fully pipelined: one op per cycle.
- rd=0 is still reported with oRegDv=1; the register file discards it.
- Port A reading a word that port B writes in the same cycle returns old data (read-first) unless the optional feature is enabled.

Optional Feature:
- FETCH_WB_STORE_COHERENT_EN defined: when a port A read and a port B write hit the same word on the same edge, oInstr returns the merged new data (write-first, respecting byte enables).
- Undefined: oInstr returns the old word (read-first).

Test Plan:
- Reset, then 4 free-running cycles -> oInstrValid 0,1,1,1; oCurPc 0x0,0x4,0x8.
- iRedirect with iNewPc=0x103 at PC 0x8 -> next cycle oInstrValid=0; the following cycle oCurPc=0x100, valid=1. Redirect and iStall together -> redirect wins.
- sb 0xAB to addr 0x11, sh 0x8001 to 0x12, then lw 0x10 -> at t+3 oRegData=0x8001AB00 (lane 0 untouched, 0 pre-loaded). lb 0x11 -> 0xFFFFFFAB; lhu 0x12 -> 0x00008001.
- lh addr 0x21, sw addr 0x22, opType 011, read and write together -> oMemErr pulses each case; RAM unchanged, no oRegDv.
- Back-to-back lw to 0x0, 0x4, 0x8 on consecutive cycles -> oRegDv for three consecutive cycles, in order, with matching oRegAddr.
- Store to word at the current fetch pc in the same cycle -> oInstr old data (macro off) or new data (macro on). iRst=0 mid-load -> oRegDv never asserts.

Source files
------------

// File: rtl/fetch_lsu_wb.sv
// Instruction fetch (port A) and RV32 load/store write-back (port B) sharing one byte-enabled
// dual-port RAM. Define FETCH_WB_STORE_COHERENT_EN for write-first fetch on same-word collisions.
module fetch_lsu_wb #(
   parameter int unsigned      cXLEN     = 32,
   parameter int unsigned      cRamDepth = 1024,
   parameter logic [cXLEN-1:0] cResetPc  = '0,
   parameter int unsigned      cRdW      = 5
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iStall,
   input  logic             iRedirect,
   input  logic [cXLEN-1:0] iNewPc,
   input  logic             iMemRead,
   input  logic             iMemWrite,
   input  logic [2:0]       iMemOpType,
   input  logic [cXLEN-1:0] iMemAddr,
   input  logic [cXLEN-1:0] iMemData,
   input  logic [cRdW-1:0]  iRdAddr,
   output logic [cXLEN-1:0] oInstr,
   output logic [cXLEN-1:0] oCurPc,
   output logic             oInstrValid,
   output logic             oRegDv,
   output logic [cRdW-1:0]  oRegAddr,
   output logic [cXLEN-1:0] oRegData,
   output logic             oMemErr
);
   localparam int unsigned cLanes = cXLEN / 8;
   localparam int unsigned cIdxW  = $clog2(cRamDepth);

   typedef enum logic {StRun, StFlush} fetchState_e;

   logic [cXLEN-1:0] mem [cRamDepth];

   fetchState_e      stateQ, stateD;
   logic [cXLEN-1:0] pcQ, pcD, curPcQ, instrQ, fetchWord;
   logic             fetchEn;
   logic [cIdxW-1:0] idxA, idxB;

   logic             legalType, misaligned, memReq, memErr, accept;
   logic             s1Load, s1Store, s1Err;
   logic [2:0]       s1Type;
   logic [cXLEN-1:0] s1Addr, s1Data;
   logic [cRdW-1:0]  s1Rd;
   logic             wrEn;
   logic [cLanes-1:0] wrBe;
   logic [cXLEN-1:0] wrData;

   logic [cXLEN-1:0] rdBQ;
   logic             s2Load;
   logic [2:0]       s2Type;
   logic [1:0]       s2Off;
   logic [cRdW-1:0]  s2Rd;
   logic [7:0]       loadByte;
   logic [15:0]      loadHalf;
   logic [cXLEN-1:0] loadExt;
   logic             regDvQ;
   logic [cRdW-1:0]  regAddrQ;
   logic [cXLEN-1:0] regDataQ;

   always_ff @(posedge iClk) begin
      if (!iRst) begin
         stateQ <= StFlush;
         pcQ    <= cResetPc;
      end else begin
         stateQ <= stateD;
         pcQ    <= pcD;
      end
   end

   always_comb begin
      stateD = stateQ;
      pcD    = pcQ;
      if (iRedirect) begin
         stateD = StFlush;
         pcD    = {iNewPc[cXLEN-1:2], 2'b00};
      end else if (!iStall) begin
         stateD = StRun;
         pcD    = pcQ + cXLEN'(4);
      end
   end

   always_comb begin
      oInstrValid = (stateQ == StRun);
      fetchEn     = !iStall;
   end

   assign idxA = pcQ[cIdxW+1:2];
   assign idxB = s1Addr[cIdxW+1:2];

`ifdef FETCH_WB_STORE_COHERENT_EN
   always_comb begin
      fetchWord = mem[idxA];
      if (wrEn && (idxA == idxB)) begin
         for (int i = 0; i < int'(cLanes); i++) begin
            if (wrBe[i]) fetchWord[8*i +: 8] = wrData[8*i +: 8];
         end
      end
   end
`else
   always_comb begin
      fetchWord = mem[idxA];
   end
`endif

   always_ff @(posedge iClk) begin
      if (!iRst) begin
         instrQ <= '0;
         curPcQ <= '0;
      end else if (fetchEn) begin
         instrQ <= fetchWord;
         curPcQ <= pcQ;
      end
   end

   assign oInstr = instrQ;
   assign oCurPc = curPcQ;

   always_comb begin
      case (iMemOpType)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legalType = 1'b1;
         default:                                legalType = 1'b0;
      endcase
      misaligned = ((iMemOpType[1:0] == 2'b01) && iMemAddr[0]) ||
                   ((iMemOpType[1:0] == 2'b10) && (iMemAddr[1:0] != 2'b00));
      memReq     = iMemRead | iMemWrite;
      accept     = (iMemRead ^ iMemWrite) & legalType & ~misaligned;
      memErr     = memReq & ~accept;
   end

   always_ff @(posedge iClk) begin
      if (!iRst) begin
         s1Load  <= 1'b0;
         s1Store <= 1'b0;
         s1Err   <= 1'b0;
         s1Type  <= '0;
         s1Addr  <= '0;
         s1Data  <= '0;
         s1Rd    <= '0;
      end else begin
         s1Load  <= accept & iMemRead;
         s1Store <= accept & iMemWrite;
         s1Err   <= memErr;
         s1Type  <= iMemOpType;
         s1Addr  <= iMemAddr;
         s1Data  <= iMemData;
         s1Rd    <= iRdAddr;
      end
   end

   assign oMemErr = s1Err;

   // Sub-word stores replicate the data across lanes; the byte enables pick the live lanes.
   always_comb begin
      wrEn = s1Store & iRst;
      case (s1Type[1:0])
         2'b00: begin
            wrData = {cLanes{s1Data[7:0]}};
            wrBe   = cLanes'(1) << s1Addr[1:0];
         end
         2'b01: begin
            wrData = {(cLanes/2){s1Data[15:0]}};
            wrBe   = cLanes'(2'b11) << {s1Addr[1], 1'b0};
         end
         default: begin
            wrData = s1Data;
            wrBe   = '1;
         end
      endcase
   end

   always_ff @(posedge iClk) begin
      if (wrEn) begin
         for (int i = 0; i < int'(cLanes); i++) begin
            if (wrBe[i]) mem[idxB][8*i +: 8] <= wrData[8*i +: 8];
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst) begin
         rdBQ   <= '0;
         s2Load <= 1'b0;
         s2Type <= '0;
         s2Off  <= '0;
         s2Rd   <= '0;
      end else begin
         rdBQ   <= mem[idxB];
         s2Load <= s1Load;
         s2Type <= s1Type;
         s2Off  <= s1Addr[1:0];
         s2Rd   <= s1Rd;
      end
   end

   always_comb begin
      loadByte = rdBQ[{s2Off, 3'b000} +: 8];
      loadHalf = rdBQ[{s2Off[1], 4'b0000} +: 16];
      case (s2Type)
         3'b000:  loadExt = {{(cXLEN-8){loadByte[7]}}, loadByte};
         3'b001:  loadExt = {{(cXLEN-16){loadHalf[15]}}, loadHalf};
         3'b100:  loadExt = {{(cXLEN-8){1'b0}}, loadByte};
         3'b101:  loadExt = {{(cXLEN-16){1'b0}}, loadHalf};
         default: loadExt = rdBQ;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (!iRst) begin
         regDvQ   <= 1'b0;
         regAddrQ <= '0;
         regDataQ <= '0;
      end else begin
         regDvQ <= s2Load;
         if (s2Load) begin
            regAddrQ <= s2Rd;
            regDataQ <= loadExt;
         end
      end
   end

   assign oRegDv   = regDvQ;
   assign oRegAddr = regAddrQ;
   assign oRegData = regDataQ;

endmodule

// File: tb/tb_fetch_lsu_wb.sv
// Randomized self-checking bench for fetch_lsu_wb against a byte-addressed behavioural model.
// Honours FETCH_WB_STORE_COHERENT_EN the same way the design does.
module tb_fetch_lsu_wb;
   localparam int unsigned Depth = 64;
   localparam int unsigned NB    = Depth * 4;

   logic        iClk = 1'b0;
   logic        iRst, iStall, iRedirect, iMemRead, iMemWrite;
   logic [31:0] iNewPc, iMemAddr, iMemData;
   logic [2:0]  iMemOpType;
   logic [4:0]  iRdAddr;
   logic [31:0] oInstr, oCurPc, oRegData;
   logic        oInstrValid, oRegDv, oMemErr;
   logic [4:0]  oRegAddr;

   always #5 iClk = ~iClk;

   fetch_lsu_wb #(.cXLEN(32), .cRamDepth(Depth), .cResetPc(32'h0), .cRdW(5)) dut (
      .iClk(iClk), .iRst(iRst), .iStall(iStall), .iRedirect(iRedirect), .iNewPc(iNewPc),
      .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iMemOpType(iMemOpType),
      .iMemAddr(iMemAddr), .iMemData(iMemData), .iRdAddr(iRdAddr),
      .oInstr(oInstr), .oCurPc(oCurPc), .oInstrValid(oInstrValid), .oRegDv(oRegDv),
      .oRegAddr(oRegAddr), .oRegData(oRegData), .oMemErr(oMemErr)
   );

   // Model: memory as bytes, fetch as pc/valid, loads as a timed queue of results.
   typedef struct {int due; logic [4:0] rd; logic [31:0] data;} ld_t;
   logic [7:0]  ramB [NB];
   logic [31:0] mPc, mCurPc, mInstr;
   bit          mValid, eErr, eRegDv;
   logic [4:0]  eRegAddr;
   logic [31:0] eRegData;
   bit          s1V, s1Ld;
   logic [2:0]  s1Type;
   logic [31:0] s1Addr, s1Data;
   logic [4:0]  s1Rd;
   ld_t         ldQ[$];
   int          cyc = 0, checks = 0, errors = 0;

   function automatic int unsigned bAddr(input logic [31:0] a);
      return a % NB;
   endfunction

   function automatic int opSize(input logic [2:0] t);
      return 1 << t[1:0];
   endfunction

   task automatic setOp(input bit r, input bit w, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rd);
      iMemRead = r; iMemWrite = w; iMemOpType = t; iMemAddr = a; iMemData = d; iRdAddr = rd;
   endtask

   task automatic idle();
      setOp(0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
   endtask

   // Advance one clock and update the model; returns 1 time unit after the edge.
   task automatic tick();
      logic [31:0] fw, raw, v;
      int unsigned base, a;
      int sz;
      bit legal, mis, nErr, nLd, nSt, wr;
      ld_t e;
      legal = iMemOpType inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      sz    = opSize(iMemOpType);
      mis   = legal && ((iMemAddr & 32'(sz - 1)) != 32'h0);
      nErr  = (iMemRead || iMemWrite) && ((iMemRead && iMemWrite) || !legal || mis);
      nLd   = iMemRead && !iMemWrite && !nErr;
      nSt   = iMemWrite && !iMemRead && !nErr;
      wr    = iRst && s1V && !s1Ld;
      base  = bAddr(mPc) & ~32'd3;
      for (int k = 0; k < 4; k++) fw[8*k +: 8] = ramB[base + k];
`ifdef FETCH_WB_STORE_COHERENT_EN
      if (wr) begin
         for (int j = 0; j < opSize(s1Type); j++) begin
            a = bAddr(s1Addr + 32'(j));
            if ((a & ~32'd3) == base) fw[8*(a % 4) +: 8] = s1Data[8*j +: 8];
         end
      end
`endif
      @(posedge iClk);
      cyc++;
      eRegDv = 0;
      if (!iRst) begin
         mPc = 32'h0; mValid = 0; mCurPc = 32'h0; mInstr = 32'h0; eErr = 0; s1V = 0;
         ldQ.delete(); eRegAddr = 5'd0; eRegData = 32'h0;
      end else begin
         if (iRedirect) begin
            mValid = 0;
            mPc    = {iNewPc[31:2], 2'b00};
         end else if (!iStall) begin
            mValid = 1; mCurPc = mPc; mInstr = fw; mPc = mPc + 32'd4;
         end
         if (s1V) begin
            sz = opSize(s1Type);
            if (!s1Ld) begin
               for (int j = 0; j < sz; j++) ramB[bAddr(s1Addr + 32'(j))] = s1Data[8*j +: 8];
            end else begin
               raw = 32'h0;
               for (int j = 0; j < sz; j++) raw[8*j +: 8] = ramB[bAddr(s1Addr + 32'(j))];
               v = raw;
               if (!s1Type[2] && sz < 4 && raw[8*sz-1]) v = raw | (32'hFFFF_FFFF << (8*sz));
               ldQ.push_back('{due: cyc + 1, rd: s1Rd, data: v});
            end
         end
         eErr = nErr; s1V = nLd || nSt; s1Ld = nLd;
         s1Type = iMemOpType; s1Addr = iMemAddr; s1Data = iMemData; s1Rd = iRdAddr;
         if (ldQ.size() > 0 && ldQ[0].due == cyc) begin
            e = ldQ.pop_front();
            eRegDv = 1; eRegAddr = e.rd; eRegData = e.data;
         end
      end
      #1;
   endtask

   task automatic test_init();
      iRst = 0; iStall = 0; iRedirect = 0; iNewPc = 32'h0; idle();
      tick(); tick();
      iRst = 1;
      for (int i = 0; i < int'(Depth); i++) begin
         setOp(0, 1, 3'b010, 32'(4 * i), $urandom, 5'd0);
         tick();
         checks++;
         if (oMemErr !== 1'b0) begin
            errors++; $display("FAIL init_err got %0b want 0", oMemErr);
         end
      end
      idle(); tick(); tick();
   endtask

   task automatic test_reset();
      iRst = 0; idle(); tick();
      iRst = 1;
      checks++;
      if ({oInstrValid, oRegDv, oMemErr} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got %b want 000", {oInstrValid, oRegDv, oMemErr});
      end
      checks++;
      if ({oCurPc, oInstr, oRegAddr, oRegData} !== 101'h0) begin
         errors++;
         $display("FAIL reset_buses got pc=%h instr=%h rd=%h data=%h want all 0",
                  oCurPc, oInstr, oRegAddr, oRegData);
      end
      for (int k = 1; k < 4; k++) begin
         tick();
         checks++;
         if (oInstrValid !== 1'b1 || oCurPc !== 32'(4 * (k - 1)) || oInstr !== mInstr) begin
            errors++;
            $display("FAIL free_run%0d got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h",
                     k, oInstrValid, oCurPc, oInstr, 4 * (k - 1), mInstr);
         end
      end
   endtask

   task automatic test_redirect();
      iRedirect = 1; iNewPc = 32'h103; tick(); iRedirect = 0;
      checks++;
      if (oInstrValid !== 1'b0) begin
         errors++; $display("FAIL redir_squash got %0b want 0", oInstrValid);
      end
      tick();
      checks++;
      if (oInstrValid !== 1'b1 || oCurPc !== 32'h100 || oInstr !== mInstr) begin
         errors++; $display("FAIL redir_target got v=%0b pc=%h instr=%h want v=1 pc=100 instr=%h",
                            oInstrValid, oCurPc, oInstr, mInstr);
      end
      iRedirect = 1; iStall = 1; iNewPc = 32'h40; tick(); iRedirect = 0; iStall = 0;
      checks++;
      if (oInstrValid !== 1'b0) begin
         errors++; $display("FAIL redir_stall_squash got %0b want 0", oInstrValid);
      end
      tick();
      checks++;
      if (oInstrValid !== 1'b1 || oCurPc !== 32'h40) begin
         errors++; $display("FAIL redir_stall_target got v=%0b pc=%h want v=1 pc=40",
                            oInstrValid, oCurPc);
      end
      iStall = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (oInstrValid !== 1'b1 || oCurPc !== 32'h40 || oInstr !== mInstr) begin
            errors++; $display("FAIL stall_hold got v=%0b pc=%h instr=%h want v=1 pc=40 instr=%h",
                               oInstrValid, oCurPc, oInstr, mInstr);
         end
      end
      iStall = 0; tick();
      checks++;
      if (oCurPc !== 32'h44) begin
         errors++; $display("FAIL stall_release got pc=%h want 44", oCurPc);
      end
   endtask

   task automatic test_fetch_random();
      for (int k = 0; k < 40; k++) begin
         iStall = ($urandom % 4) == 0; iRedirect = ($urandom % 8) == 0; iNewPc = $urandom;
         tick();
         checks++;
         if (oInstrValid !== mValid || (mValid && (oCurPc !== mCurPc || oInstr !== mInstr))) begin
            errors++; $display("FAIL fetch_rand got v=%0b pc=%h instr=%h want v=%0b pc=%h instr=%h",
                               oInstrValid, oCurPc, oInstr, mValid, mCurPc, mInstr);
         end
      end
      iStall = 0; iRedirect = 0;
   endtask

   task automatic test_subword();
      logic [31:0] wantData [3];
      logic [4:0]  wantRd [3];
      int seen = 0;
      wantData[0] = 32'h8001_AB00; wantData[1] = 32'hFFFF_FFAB; wantData[2] = 32'h0000_8001;
      wantRd[0] = 5'd3; wantRd[1] = 5'd4; wantRd[2] = 5'd5;
      setOp(0, 1, 3'b010, 32'h10, 32'h0, 5'd0); tick();
      setOp(0, 1, 3'b000, 32'h11, 32'h1234_56AB, 5'd0); tick();
      setOp(0, 1, 3'b001, 32'h12, 32'hDEAD_8001, 5'd0); tick();
      setOp(1, 0, 3'b010, 32'h10, 32'h0, 5'd3); tick();
      setOp(1, 0, 3'b000, 32'h11, 32'h0, 5'd4); tick();
      setOp(1, 0, 3'b101, 32'h12, 32'h0, 5'd5); tick();
      idle();
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (oRegDv !== eRegDv) begin
            errors++; $display("FAIL subword_dv cyc %0d got %0b want %0b", k, oRegDv, eRegDv);
         end
         if (oRegDv === 1'b1 && seen < 3) begin
            checks++;
            if (oRegAddr !== wantRd[seen] || oRegData !== wantData[seen]) begin
               errors++; $display("FAIL subword_load%0d got rd=%0d data=%h want rd=%0d data=%h",
                                  seen, oRegAddr, oRegData, wantRd[seen], wantData[seen]);
            end
            seen++;
         end
         tick();
      end
      checks++;
      if (seen != 3) begin
         errors++; $display("FAIL subword_count got %0d want 3", seen);
      end
   endtask

   task automatic test_errors();
      bit          er [5], ew [5];
      logic [2:0]  et [5];
      logic [31:0] ea [5];
      er = '{1, 0, 1, 1, 0}; ew = '{0, 1, 0, 1, 1};
      et = '{3'b001, 3'b010, 3'b011, 3'b010, 3'b011};
      ea = '{32'h21, 32'h22, 32'h20, 32'h20, 32'h20};
      setOp(0, 1, 3'b010, 32'h20, 32'hCAFE_F00D, 5'd0); tick();
      for (int i = 0; i < 5; i++) begin
         setOp(er[i], ew[i], et[i], ea[i], 32'hFFFF_FFFF, 5'd1); tick(); idle();
         checks++;
         if (oMemErr !== 1'b1) begin
            errors++; $display("FAIL err_pulse%0d got %0b want 1", i, oMemErr);
         end
         for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (oMemErr !== 1'b0 || oRegDv !== 1'b0) begin
               errors++; $display("FAIL err_after%0d got err=%0b dv=%0b want 0 0",
                                  i, oMemErr, oRegDv);
            end
         end
      end
      setOp(1, 0, 3'b010, 32'h20, 32'h0, 5'd6); tick(); idle(); tick(); tick();
      checks++;
      if (oRegDv !== 1'b1 || oRegAddr !== 5'd6 || oRegData !== 32'hCAFE_F00D) begin
         errors++; $display("FAIL err_ram_intact got dv=%0b rd=%0d data=%h want 1 6 cafef00d",
                            oRegDv, oRegAddr, oRegData);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         setOp(1, 0, 3'b010, 32'(4 * i), 32'h0, 5'(7 + i)); tick();
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (oRegDv !== 1'b1 || oRegAddr !== 5'(7 + i) || oRegData !== eRegData) begin
            errors++; $display("FAIL b2b%0d got dv=%0b rd=%0d data=%h want 1 %0d %h",
                               i, oRegDv, oRegAddr, oRegData, 7 + i, eRegData);
         end
         tick();
      end
      checks++;
      if (oRegDv !== 1'b0) begin
         errors++; $display("FAIL b2b_end got dv=%0b want 0", oRegDv);
      end
   endtask

   task automatic test_coherent();
      logic [31:0] p, oldW, newW, want;
      logic [7:0]  nb;
      int unsigned b;
      iStall = 0; iRedirect = 0; idle();
      p = mPc + 32'd4; b = bAddr(p) & ~32'd3;
      oldW = {ramB[b + 3], ramB[b + 2], ramB[b + 1], ramB[b]};
      newW = oldW ^ 32'hA5C3_5A3C;
      setOp(0, 1, 3'b010, p, newW, 5'd0); tick(); idle(); tick();
`ifdef FETCH_WB_STORE_COHERENT_EN
      want = newW;
`else
      want = oldW;
`endif
      checks++;
      if (oInstrValid !== 1'b1 || oCurPc !== p || oInstr !== want) begin
         errors++; $display("FAIL coll_word got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h",
                            oInstrValid, oCurPc, oInstr, p, want);
      end
      p = mPc + 32'd4; b = bAddr(p) & ~32'd3;
      oldW = {ramB[b + 3], ramB[b + 2], ramB[b + 1], ramB[b]};
      nb = ramB[b + 1] ^ 8'hFF;
      setOp(0, 1, 3'b000, p + 32'd1, {24'hABCDEF, nb}, 5'd0); tick(); idle(); tick();
`ifdef FETCH_WB_STORE_COHERENT_EN
      want = {oldW[31:16], nb, oldW[7:0]};
`else
      want = oldW;
`endif
      checks++;
      if (oCurPc !== p || oInstr !== want) begin
         errors++; $display("FAIL coll_byte got pc=%h instr=%h want pc=%h instr=%h",
                            oCurPc, oInstr, p, want);
      end
   endtask

   task automatic test_reset_mid_load();
      setOp(1, 0, 3'b010, 32'h4, 32'h0, 5'd10); tick(); idle(); tick();
      iRst = 0; tick(); iRst = 1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (oRegDv !== 1'b0) begin
            errors++; $display("FAIL rst_mid_load cyc %0d got dv=%0b want 0", k, oRegDv);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [2:0] t;
      logic [31:0] a;
      int op;
      for (int k = 0; k < 120; k++) begin
         iRst = ($urandom % 40) != 0;
         iStall = ($urandom % 5) == 0; iRedirect = ($urandom % 12) == 0; iNewPc = $urandom;
         op = $urandom % 3;
         t = ($urandom % 8 == 0) ? 3'($urandom) : 3'($urandom % 3) | (($urandom % 2 == 0) ? 3'b000 : 3'b100);
         if (t == 3'b110) t = 3'b010;
         a = $urandom;
         if ($urandom % 5 != 0) a = a & ~32'(opSize(t) - 1);
         setOp(op == 1 || ($urandom % 10 == 0), op == 2, t, a, $urandom, 5'($urandom));
         tick();
         checks++;
         if (oMemErr !== eErr || oRegDv !== eRegDv ||
             (eRegDv && (oRegAddr !== eRegAddr || oRegData !== eRegData))) begin
            errors++; $display("FAIL rand_lsu got err=%0b dv=%0b rd=%0d data=%h want %0b %0b %0d %h",
                               oMemErr, oRegDv, oRegAddr, oRegData, eErr, eRegDv, eRegAddr, eRegData);
         end
         checks++;
         if (oInstrValid !== mValid || (mValid && (oCurPc !== mCurPc || oInstr !== mInstr))) begin
            errors++; $display("FAIL rand_fetch got v=%0b pc=%h instr=%h want v=%0b pc=%h instr=%h",
                               oInstrValid, oCurPc, oInstr, mValid, mCurPc, mInstr);
         end
      end
      iRst = 1; iStall = 0; iRedirect = 0; idle();
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (oRegDv !== eRegDv || (eRegDv && oRegData !== eRegData)) begin
            errors++; $display("FAIL rand_drain got dv=%0b data=%h want %0b %h",
                               oRegDv, oRegData, eRegDv, eRegData);
         end
      end
   endtask

   initial begin
      test_init();
      test_reset();
      test_redirect();
      test_fetch_random();
      test_subword();
      test_errors();
      test_back_to_back();
      test_coherent();
      test_reset_mid_load();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
